// File: rtl/control_ajuste_fecha.sv
// Date-setting controller: buttons -> single-cycle inc/dec strobes for day/month/year,
// with day clamping after month/year changes. Optional auto-repeat via `AUTOREPEAT_EN.
// Ports: clk, reset_n (async, active-low); btn_mode/btn_up/btn_down raw buttons;
//   month_in[3:0], day_in[4:0], leap_in from the counters; field[1:0], setting;
//   day/month/year inc/dec strobes; day_load + day_load_val[4:0] clamp load.
`timescale 1ns/1ps

module control_ajuste_fecha #(
    parameter int CNT_W          = 32,
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] month_in,
    input  logic [4:0] day_in,
    input  logic       leap_in,
    output logic [1:0] field,
    output logic       setting,
    output logic       day_inc,
    output logic       day_dec,
    output logic       month_inc,
    output logic       month_dec,
    output logic       year_inc,
    output logic       year_dec,
    output logic       day_load,
    output logic [4:0] day_load_val
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DAY   = 2'd1,
        ST_MONTH = 2'd2,
        ST_YEAR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_setting;
    logic [2:0]       r_mode_sh, r_up_sh, r_dn_sh;
    logic [CNT_W-1:0] r_idle;
    logic             r_def_v, r_def_dn;
    logic             r_clamp_pend;
    logic             r_day_inc, r_day_dec, r_month_inc, r_month_dec;
    logic             r_year_inc, r_year_dec;
    logic             r_day_load;
    logic [4:0]       r_day_load_val;

    logic       w_mode_rise, w_up_rise, w_dn_rise, w_both;
    logic       w_rep_up, w_rep_dn;
    logic       w_up_new, w_dn_new, w_new_any;
    logic       w_in_set, w_act, w_timeout, w_hold_off;
    logic       w_emit, w_emit_dn;
    logic [4:0] w_max;
    state_t     w_next;

    // [0],[1] form the synchronizer; [2] is the previous value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_sh <= 3'b000;
            r_up_sh   <= 3'b000;
            r_dn_sh   <= 3'b000;
        end else begin
            r_mode_sh <= {r_mode_sh[1:0], btn_mode};
            r_up_sh   <= {r_up_sh[1:0], btn_up};
            r_dn_sh   <= {r_dn_sh[1:0], btn_down};
        end
    end

    assign w_mode_rise = r_mode_sh[1] & ~r_mode_sh[2];
    assign w_up_rise   = r_up_sh[1] & ~r_up_sh[2];
    assign w_dn_rise   = r_dn_sh[1] & ~r_dn_sh[2];
    assign w_both      = r_up_sh[1] & r_dn_sh[1];
    assign w_in_set    = (r_state != ST_RUN);
    assign w_act       = w_mode_rise | w_up_rise | w_dn_rise;
    assign w_timeout   = w_in_set & ~w_act & (r_idle == LP_TO_LAST);
    assign w_next      = state_t'(r_state + 2'd1);

    // A month/year strobe on the outputs now means a clamp is computed next cycle
    assign w_hold_off = r_month_inc | r_month_dec | r_year_inc | r_year_dec;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] LP_HOLD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LP_RELOAD =
        CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

    logic [CNT_W-1:0] r_hold;
    logic             w_hold_up, w_hold_dn, w_hold_ok, w_fire;

    assign w_hold_up = r_up_sh[1] & ~r_dn_sh[1];
    assign w_hold_dn = r_dn_sh[1] & ~r_up_sh[1];
    assign w_hold_ok = w_in_set & ~w_mode_rise & ~w_timeout &
                       (w_hold_up | w_hold_dn);
    assign w_fire    = w_hold_ok & (r_hold == LP_HOLD);
    assign w_rep_up  = w_fire & w_hold_up;
    assign w_rep_dn  = w_fire & w_hold_dn;

    // Counts cycles held since the edge; reload makes later fires REPEAT apart
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (!w_hold_ok) begin
            r_hold <= '0;
        end else if (w_up_rise | w_dn_rise) begin
            r_hold <= CNT_W'(1);
        end else if (w_fire) begin
            r_hold <= LP_RELOAD;
        end else begin
            r_hold <= r_hold + CNT_W'(1);
        end
    end
`else
    assign w_rep_up = 1'b0;
    assign w_rep_dn = 1'b0;
`endif

    assign w_up_new  = (w_up_rise | w_rep_up) & ~w_both;
    assign w_dn_new  = (w_dn_rise | w_rep_dn) & ~w_both;
    assign w_new_any = w_up_new | w_dn_new;

    // A deferred request takes priority over a fresh one
    assign w_emit    = w_in_set & ~w_mode_rise & ~w_timeout & ~w_hold_off &
                       (r_def_v | w_new_any);
    assign w_emit_dn = r_def_v ? r_def_dn : w_dn_new;

    always_comb begin
        w_max = 5'd31;
        case (month_in)
            4'd4, 4'd6, 4'd9, 4'd11: w_max = 5'd30;
            4'd2:                    w_max = leap_in ? 5'd29 : 5'd28;
            default:                 w_max = 5'd31;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RUN;
            r_setting      <= 1'b0;
            r_idle         <= '0;
            r_def_v        <= 1'b0;
            r_def_dn       <= 1'b0;
            r_clamp_pend   <= 1'b0;
            r_day_inc      <= 1'b0;
            r_day_dec      <= 1'b0;
            r_month_inc    <= 1'b0;
            r_month_dec    <= 1'b0;
            r_year_inc     <= 1'b0;
            r_year_dec     <= 1'b0;
            r_day_load     <= 1'b0;
            r_day_load_val <= 5'd0;
        end else begin
            r_day_inc    <= 1'b0;
            r_day_dec    <= 1'b0;
            r_month_inc  <= 1'b0;
            r_month_dec  <= 1'b0;
            r_year_inc   <= 1'b0;
            r_year_dec   <= 1'b0;
            r_day_load   <= 1'b0;
            r_clamp_pend <= w_hold_off;

            if (r_clamp_pend && (day_in > w_max)) begin
                r_day_load     <= 1'b1;
                r_day_load_val <= w_max;
            end

            if (!w_in_set || w_mode_rise || w_timeout) begin
                r_idle  <= '0;
                r_def_v <= 1'b0;
                if (w_mode_rise) begin
                    r_state   <= w_next;
                    r_setting <= (w_next != ST_RUN);
                end else if (w_timeout) begin
                    r_state   <= ST_RUN;
                    r_setting <= 1'b0;
                end
            end else begin
                r_idle <= w_act ? '0 : r_idle + CNT_W'(1);
                if (w_hold_off) begin
                    // Hold a new request one cycle while the clamp is evaluated
                    if (!r_def_v && w_new_any) begin
                        r_def_v  <= 1'b1;
                        r_def_dn <= w_dn_new;
                    end
                end else begin
                    r_def_v  <= r_def_v & w_new_any;
                    r_def_dn <= w_dn_new;
                end
            end

            if (w_emit) begin
                case (r_state)
                    ST_DAY: begin
                        r_day_inc <= ~w_emit_dn;
                        r_day_dec <= w_emit_dn;
                    end
                    ST_MONTH: begin
                        r_month_inc <= ~w_emit_dn;
                        r_month_dec <= w_emit_dn;
                    end
                    ST_YEAR: begin
                        r_year_inc <= ~w_emit_dn;
                        r_year_dec <= w_emit_dn;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign field        = r_state;
    assign setting      = r_setting;
    assign day_inc      = r_day_inc;
    assign day_dec      = r_day_dec;
    assign month_inc    = r_month_inc;
    assign month_dec    = r_month_dec;
    assign year_inc     = r_year_inc;
    assign year_dec     = r_year_dec;
    assign day_load     = r_day_load;
    assign day_load_val = r_day_load_val;

endmodule
